bp_history_trainer: RTL and testbench

Sequential controller that owns the perceptron branch predictor's global history register (GHR) and sequences all weight-table training. It sits between the fetch-side predictor and the backend resolve path. Predicted conditional branches are pushed in program order. Resolutions arrive oldest-first. On a mispredict the block repairs history, flushes the front end and runs a read-modify-write on the weight table. The block stalls fetch while training is in progress.

---
 rtl/bp_history_trainer.sv | 165 ++++++++++++++++
 tb/tb_bp_history_trainer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_history_trainer.sv
// Perceptron GHR owner and weight-table trainer; BP_SAT_WEIGHTS_EN selects saturating weights.
// Latency: GHR/pending visible next cycle; mispredict -> flush+read T+1, capture T+2, write T+3.
// Backpressure: o_push_ready low while training or when fewer than 4 GHR entries are free.
module bp_history_trainer #(
    parameter int GHR_DEPTH = 20,
    parameter int ROWS      = 228,
    parameter int HIST      = 8,
    parameter int WEIGHT_W  = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_push_valid,
    input  logic [2:0]                     i_push_num,
    input  logic [131:0]                   i_push_bus,
    output logic                           o_push_ready,
    input  logic                           i_resolve_valid,
    input  logic                           i_resolve_taken,
    output logic [GHR_DEPTH*33-1:0]        o_ghr,
    output logic [4:0]                     o_pending,
    output logic                           o_flush,
    output logic                           o_fetch_stall,
    output logic                           o_wt_rd_en,
    output logic [7:0]                     o_wt_addr,
    input  logic [(HIST+1)*WEIGHT_W-1:0]   i_wt_rd_data,
    output logic                           o_wt_wr_en,
    output logic [(HIST+1)*WEIGHT_W-1:0]   o_wt_wr_data
);
    localparam int ENT_W = 33;
    localparam int ROW_W = (HIST+1)*WEIGHT_W;
    localparam int IDX_W = $clog2(GHR_DEPTH);

    typedef enum logic [1:0] {IDLE, READ, CAPT, WRITE} state_t;

    state_t             state;
    logic [ENT_W-1:0]   ghr     [GHR_DEPTH];
    logic [ENT_W-1:0]   ghr_nxt [GHR_DEPTH];
    logic [ENT_W-1:0]   rewound [GHR_DEPTH];
    logic [ENT_W-1:0]   slot    [4];
    logic [4:0]         pending, pending_nxt;
    logic [IDX_W-1:0]   oldest;
    logic               push_acc, res_act, res_ok, mispredict;
    logic [7:0]         mis_addr;
    logic               t_q;
    logic [HIST-1:0]    h_q;
    logic [ROW_W-1:0]   new_row;

    function automatic logic [WEIGHT_W-1:0] bump(input logic [WEIGHT_W-1:0] w, input logic up);
`ifdef BP_SAT_WEIGHTS_EN
        if (up && w == {1'b0, {(WEIGHT_W-1){1'b1}}})
            return w;
        if (!up && w == {1'b1, {(WEIGHT_W-1){1'b0}}})
            return w;
`endif
        return up ? w + WEIGHT_W'(1) : w - WEIGHT_W'(1);
    endfunction

    assign o_push_ready = (state == IDLE) && (pending <= 5'(GHR_DEPTH-4));
    assign o_pending    = pending;

    always_comb begin
        for (int k = 0; k < GHR_DEPTH; k++)
            o_ghr[k*ENT_W +: ENT_W] = ghr[k];
    end

    always_comb begin
        for (int s = 0; s < 4; s++)
            slot[s] = i_push_bus[s*ENT_W +: ENT_W];
        oldest     = (pending == 5'd0) ? '0 : IDX_W'(pending - 5'd1);
        push_acc   = i_push_valid && o_push_ready;
        res_act    = i_resolve_valid && (pending != 5'd0);
        mispredict = res_act && (i_resolve_taken != ghr[oldest][0]);
        res_ok     = res_act && !mispredict;

        // Rewind: the mispredicted entry drops to index 0, younger speculation is lost.
        for (int k = 0; k < GHR_DEPTH; k++) begin
            logic [IDX_W:0] src;
            src        = (IDX_W+1)'(k) + {1'b0, oldest};
            rewound[k] = '0;
            if (src < (IDX_W+1)'(GHR_DEPTH))
                rewound[k] = ghr[src[IDX_W-1:0]];
        end
        rewound[0][0] = ~rewound[0][0];
        mis_addr      = 8'(rewound[0][32:1] % ROWS);

        for (int k = 0; k < GHR_DEPTH; k++) begin
            ghr_nxt[k] = ghr[k];
            if (mispredict)
                ghr_nxt[k] = rewound[k];
            else if (push_acc) begin
                if (k < int'(i_push_num))
                    ghr_nxt[k] = slot[2'(int'(i_push_num) - 1 - k)];
                else
                    ghr_nxt[k] = ghr[IDX_W'(k - int'(i_push_num))];
            end
        end

        if (mispredict)
            pending_nxt = '0;
        else
            pending_nxt = pending + (push_acc ? {2'b00, i_push_num} : 5'd0)
                                  - (res_ok ? 5'd1 : 5'd0);
    end

    always_comb begin
        for (int j = 0; j < HIST; j++)
            new_row[j*WEIGHT_W +: WEIGHT_W] = bump(i_wt_rd_data[j*WEIGHT_W +: WEIGHT_W], h_q[j] == t_q);
        new_row[HIST*WEIGHT_W +: WEIGHT_W] = bump(i_wt_rd_data[HIST*WEIGHT_W +: WEIGHT_W], t_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < GHR_DEPTH; k++)
                ghr[k] <= '0;
            pending <= '0;
        end else begin
            for (int k = 0; k < GHR_DEPTH; k++)
                ghr[k] <= ghr_nxt[k];
            pending <= pending_nxt;
        end
    end

    // Mispredicts only occur in IDLE: pending is forced to 0 for the whole training run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_flush       <= 1'b0;
            o_fetch_stall <= 1'b0;
            o_wt_rd_en    <= 1'b0;
            o_wt_addr     <= '0;
            o_wt_wr_en    <= 1'b0;
            o_wt_wr_data  <= '0;
            t_q           <= 1'b0;
            h_q           <= '0;
        end else begin
            o_flush <= 1'b0;
            case (state)
                IDLE: if (mispredict) begin
                    state         <= READ;
                    o_flush       <= 1'b1;
                    o_fetch_stall <= 1'b1;
                    o_wt_rd_en    <= 1'b1;
                    o_wt_addr     <= mis_addr;
                    t_q           <= i_resolve_taken;
                    for (int j = 0; j < HIST; j++)
                        h_q[j] <= rewound[j+1][0];
                end
                READ: begin
                    state      <= CAPT;
                    o_wt_rd_en <= 1'b0;
                end
                CAPT: begin
                    state        <= WRITE;
                    o_wt_wr_en   <= 1'b1;
                    o_wt_wr_data <= new_row;
                end
                WRITE: begin
                    state         <= IDLE;
                    o_wt_wr_en    <= 1'b0;
                    o_fetch_stall <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bp_history_trainer.sv
// Bench for bp_history_trainer: reference GHR model plus a queue of expected weight-table writes.
module tb_bp_history_trainer;
    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_push_valid = 1'b0;
    logic [2:0]   i_push_num = '0;
    logic [131:0] i_push_bus = '0;
    logic         o_push_ready;
    logic         i_resolve_valid = 1'b0;
    logic         i_resolve_taken = 1'b0;
    logic [659:0] o_ghr;
    logic [4:0]   o_pending;
    logic         o_flush, o_fetch_stall, o_wt_rd_en, o_wt_wr_en;
    logic [7:0]   o_wt_addr;
    logic [71:0]  rd_row = '0;
    logic [71:0]  o_wt_wr_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [71:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [32:0] m_ghr [20];
    int          m_pend = 0;
    int          m_busy = 0;

    bp_history_trainer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_push_valid(i_push_valid), .i_push_num(i_push_num), .i_push_bus(i_push_bus),
        .o_push_ready(o_push_ready),
        .i_resolve_valid(i_resolve_valid), .i_resolve_taken(i_resolve_taken),
        .o_ghr(o_ghr), .o_pending(o_pending), .o_flush(o_flush), .o_fetch_stall(o_fetch_stall),
        .o_wt_rd_en(o_wt_rd_en), .o_wt_addr(o_wt_addr), .i_wt_rd_data(rd_row),
        .o_wt_wr_en(o_wt_wr_en), .o_wt_wr_data(o_wt_wr_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [32:0] ent(input logic [31:0] pc, input logic t);
        return {pc, t};
    endfunction

    function automatic logic [131:0] mk_bus(input logic [32:0] s0, input logic [32:0] s1,
                                            input logic [32:0] s2, input logic [32:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [7:0] wbump(input logic [7:0] w, input logic up);
`ifdef BP_SAT_WEIGHTS_EN
        if (up && w == 8'h7F) return w;
        if (!up && w == 8'h80) return w;
`endif
        return up ? w + 8'd1 : w - 8'd1;
    endfunction

    function automatic logic [659:0] exp_ghr();
        logic [659:0] r;
        for (int k = 0; k < 20; k++) r[k*33 +: 33] = m_ghr[k];
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 20; k++) m_ghr[k] = '0;
        m_pend = 0;
        m_busy = 0;
        sb.delete();
    endtask

    // Drives one cycle of stimulus and advances the reference model; scoreboard entries queued here.
    task automatic cycle(input logic pv, input logic [2:0] pn, input logic [131:0] pb,
                         input logic rv, input logic rt);
        logic        acc, act, mis;
        logic [32:0] nx [20];
        logic [7:0]  h;
        wr_t         w;
        i_push_valid = pv; i_push_num = pn; i_push_bus = pb;
        i_resolve_valid = rv; i_resolve_taken = rt;
        acc = pv && (m_busy == 0) && (m_pend <= 16);
        act = rv && (m_pend > 0);
        mis = act && (rt != m_ghr[m_pend-1][0]);
        if (m_busy > 0) m_busy--;
        if (mis) begin
            for (int k = 0; k < 20; k++) nx[k] = (k + m_pend - 1 < 20) ? m_ghr[k+m_pend-1] : '0;
            nx[0][0] = ~nx[0][0];
            for (int j = 0; j < 8; j++) h[j] = nx[j+1][0];
            w.addr = 8'(nx[0][32:1] % 228);
            for (int j = 0; j < 8; j++) w.data[j*8 +: 8] = wbump(rd_row[j*8 +: 8], h[j] == rt);
            w.data[64 +: 8] = wbump(rd_row[64 +: 8], rt);
            sb.push_back(w);
            m_ghr = nx;
            m_pend = 0;
            m_busy = 3;
        end else begin
            if (act) m_pend--;
            if (acc) begin
                for (int k = 19; k >= 0; k--) begin
                    if (k >= int'(pn)) m_ghr[k] = m_ghr[k-int'(pn)];
                    else m_ghr[k] = pb[(int'(pn)-1-k)*33 +: 33];
                end
                m_pend += int'(pn);
            end
        end
        @(posedge i_clk); #1;
        i_push_valid = 1'b0; i_resolve_valid = 1'b0; i_push_num = '0; i_push_bus = '0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        m_reset();
        repeat (5) @(posedge i_clk);
        #1;
        checks++; if (o_ghr !== '0) begin errors++; $display("FAIL reset_ghr got %h want 0", o_ghr); end
        checks++; if (o_pending !== 5'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", o_pending); end
        checks++; if (o_push_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_push_ready); end
        checks++; if (o_fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", o_fetch_stall); end
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", o_flush); end
        checks++; if ({o_wt_rd_en, o_wt_wr_en, o_wt_addr} !== 10'd0) begin errors++; $display("FAIL reset_wt_ctrl got %b want 0", {o_wt_rd_en, o_wt_wr_en, o_wt_addr}); end
        checks++; if (o_wt_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", o_wt_wr_data); end
    endtask

    task automatic test_push();
        cycle(1'b1, 3'd3, mk_bus(ent(32'h100, 1'b0), ent(32'h104, 1'b1), ent(32'h108, 1'b0), '0), 1'b0, 1'b0);
        checks++; if (o_ghr[0 +: 33] !== ent(32'h108, 1'b0)) begin errors++; $display("FAIL push_e0 got %h want %h", o_ghr[0 +: 33], ent(32'h108, 1'b0)); end
        checks++; if (o_ghr[33 +: 33] !== ent(32'h104, 1'b1)) begin errors++; $display("FAIL push_e1 got %h want %h", o_ghr[33 +: 33], ent(32'h104, 1'b1)); end
        checks++; if (o_ghr[66 +: 33] !== ent(32'h100, 1'b0)) begin errors++; $display("FAIL push_e2 got %h want %h", o_ghr[66 +: 33], ent(32'h100, 1'b0)); end
        checks++; if (o_pending !== 5'd3) begin errors++; $display("FAIL push_pending got %0d want 3", o_pending); end
        checks++; if (o_ghr !== exp_ghr()) begin errors++; $display("FAIL push_ghr got %h want %h", o_ghr, exp_ghr()); end
    endtask

    task automatic test_resolve_correct();
        logic [2:0] outc;
        outc = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 3'd0, '0, 1'b1, outc[i]);
            checks++; if (o_pending !== 5'(2 - i)) begin errors++; $display("FAIL resolve_pending got %0d want %0d", o_pending, 2 - i); end
            checks++; if (o_ghr !== exp_ghr()) begin errors++; $display("FAIL resolve_ghr got %h want %h", o_ghr, exp_ghr()); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]  pc;
        logic [131:0] bus;
        int           exp_p[5];
        logic [4:0]   exp_r;
        exp_p = '{19, 18, 17, 16, 19};
        exp_r = 5'b01000;
        pc = 32'h1000;
        for (int p = 0; p < 5; p++) begin
            bus = mk_bus(ent(pc, 1'b0), ent(pc + 4, 1'b1), ent(pc + 8, 1'b1), ent(pc + 12, 1'b0));
            cycle(1'b1, 3'd4, bus, 1'b0, 1'b0);
            pc += 16;
            if (p == 3) begin
                checks++; if (o_pending !== 5'd16 || o_push_ready !== 1'b1) begin errors++; $display("FAIL bp_16 got pend=%0d rdy=%b want 16/1", o_pending, o_push_ready); end
            end
        end
        checks++; if (o_pending !== 5'd20 || o_push_ready !== 1'b0) begin errors++; $display("FAIL bp_full got pend=%0d rdy=%b want 20/0", o_pending, o_push_ready); end
        bus = mk_bus(ent(pc, 1'b1), ent(pc + 4, 1'b0), ent(pc + 8, 1'b0), ent(pc + 12, 1'b1));
        pc += 16;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3'd4, bus, 1'b1, m_ghr[m_pend-1][0]);
            checks++; if (o_pending !== 5'(exp_p[i]) || o_push_ready !== exp_r[i]) begin errors++; $display("FAIL bp_hold%0d got pend=%0d rdy=%b want %0d/%b", i, o_pending, o_push_ready, exp_p[i], exp_r[i]); end
        end
        checks++; if (o_ghr !== exp_ghr()) begin errors++; $display("FAIL bp_ghr got %h want %h", o_ghr, exp_ghr()); end
        for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, '0, 1'b1, m_ghr[m_pend-1][0]);
        cycle(1'b1, 3'd2, mk_bus(ent(pc, 1'b1), ent(pc + 4, 1'b0), '0, '0), 1'b1, m_ghr[m_pend-1][0]);
        checks++; if (o_pending !== 5'd15) begin errors++; $display("FAIL bp_push_resolve got %0d want 15", o_pending); end
        checks++; if (o_ghr !== exp_ghr()) begin errors++; $display("FAIL bp_push_resolve_ghr got %h want %h", o_ghr, exp_ghr()); end
    endtask

    task automatic test_mispredict();
        int  stall_cnt;
        wr_t w;
        for (int i = 0; i < 25 && m_pend > 0; i++) cycle(1'b0, 3'd0, '0, 1'b1, m_ghr[m_pend-1][0]);
        checks++; if (o_pending !== 5'd0) begin errors++; $display("FAIL mp_drain got %0d want 0", o_pending); end
        cycle(1'b1, 3'd4, mk_bus(ent(32'h300, 1'b1), ent(32'h304, 1'b1), ent(32'h308, 1'b1), ent(32'h30C, 1'b1)), 1'b0, 1'b0);
        cycle(1'b1, 3'd4, mk_bus(ent(32'h310, 1'b1), ent(32'h314, 1'b1), ent(32'h318, 1'b1), ent(32'h31C, 1'b1)), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, '0, 1'b1, 1'b1);
        cycle(1'b1, 3'd2, mk_bus(ent(32'h1E4, 1'b0), ent(32'h1E8, 1'b1), '0, '0), 1'b0, 1'b0);
        checks++; if (o_pending !== 5'd2) begin errors++; $display("FAIL mp_setup got %0d want 2", o_pending); end
        rd_row = '0;
        // The coincident push must be dropped in favour of the flush.
        cycle(1'b1, 3'd1, mk_bus(ent(32'hDEADBEE0, 1'b1), '0, '0, '0), 1'b1, 1'b1);
        stall_cnt = int'(o_fetch_stall);
        checks++; if (o_flush !== 1'b1 || o_wt_rd_en !== 1'b1) begin errors++; $display("FAIL mp_t1_ctrl got flush=%b rd=%b want 1/1", o_flush, o_wt_rd_en); end
        checks++; if (o_wt_addr !== 8'd28) begin errors++; $display("FAIL mp_addr got %0d want 28", o_wt_addr); end
        checks++; if (o_pending !== 5'd0 || o_push_ready !== 1'b0) begin errors++; $display("FAIL mp_t1_pend got pend=%0d rdy=%b want 0/0", o_pending, o_push_ready); end
        checks++; if (o_ghr[0 +: 33] !== ent(32'h1E4, 1'b1)) begin errors++; $display("FAIL mp_e0 got %h want %h", o_ghr[0 +: 33], ent(32'h1E4, 1'b1)); end
        checks++; if (o_ghr !== exp_ghr()) begin errors++; $display("FAIL mp_ghr got %h want %h", o_ghr, exp_ghr()); end
        cycle(1'b0, 3'd0, '0, 1'b1, 1'b0);
        stall_cnt += int'(o_fetch_stall);
        checks++; if ({o_flush, o_wt_rd_en, o_wt_wr_en} !== 3'b000 || o_pending !== 5'd0) begin errors++; $display("FAIL mp_t2 got f/r/w=%b pend=%0d want 000/0", {o_flush, o_wt_rd_en, o_wt_wr_en}, o_pending); end
        cycle(1'b0, 3'd0, '0, 1'b0, 1'b0);
        stall_cnt += int'(o_fetch_stall);
        checks++;
        if (o_wt_wr_en !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL mp_write_present got wr_en=%b queued=%0d want 1/1", o_wt_wr_en, sb.size());
        end else begin
            w = sb.pop_front();
            if (o_wt_addr !== w.addr || o_wt_wr_data !== w.data) begin errors++; $display("FAIL mp_write got %0d/%h want %0d/%h", o_wt_addr, o_wt_wr_data, w.addr, w.data); end
        end
        checks++; if (o_wt_wr_data !== {9{8'h01}}) begin errors++; $display("FAIL mp_row got %h want %h", o_wt_wr_data, {9{8'h01}}); end
        cycle(1'b0, 3'd0, '0, 1'b0, 1'b0);
        stall_cnt += int'(o_fetch_stall);
        checks++; if (o_wt_wr_en !== 1'b0 || o_push_ready !== 1'b1) begin errors++; $display("FAIL mp_t4 got wr=%b rdy=%b want 0/1", o_wt_wr_en, o_push_ready); end
        checks++; if (stall_cnt != 3) begin errors++; $display("FAIL mp_stall_len got %0d want 3", stall_cnt); end
    endtask

    task automatic test_saturate();
        wr_t         w;
        logic [71:0] want;
`ifdef BP_SAT_WEIGHTS_EN
        want = {9{8'h7F}};
`else
        want = {9{8'h80}};
`endif
        cycle(1'b1, 3'd2, mk_bus(ent(32'h200, 1'b0), ent(32'h204, 1'b0), '0, '0), 1'b0, 1'b0);
        rd_row = {9{8'h7F}};
        cycle(1'b0, 3'd0, '0, 1'b1, 1'b1);
        checks++; if (o_wt_addr !== 8'd56 || o_flush !== 1'b1) begin errors++; $display("FAIL sat_addr got %0d flush=%b want 56/1", o_wt_addr, o_flush); end
        cycle(1'b0, 3'd0, '0, 1'b0, 1'b0);
        cycle(1'b0, 3'd0, '0, 1'b0, 1'b0);
        checks++;
        if (o_wt_wr_en !== 1'b1 || sb.size() == 0) begin
            errors++; $display("FAIL sat_write_present got wr_en=%b queued=%0d want 1/1", o_wt_wr_en, sb.size());
        end else begin
            w = sb.pop_front();
            if (o_wt_wr_data !== w.data || o_wt_addr !== w.addr) begin errors++; $display("FAIL sat_write got %0d/%h want %0d/%h", o_wt_addr, o_wt_wr_data, w.addr, w.data); end
        end
        checks++; if (o_wt_wr_data !== want) begin errors++; $display("FAIL sat_row got %h want %h", o_wt_wr_data, want); end
        cycle(1'b0, 3'd0, '0, 1'b0, 1'b0);
        checks++; if (sb.size() != 0 || o_fetch_stall !== 1'b0) begin errors++; $display("FAIL sat_drain got queued=%0d stall=%b want 0/0", sb.size(), o_fetch_stall); end
    endtask

    task automatic test_reset_mid_training();
        int wr_seen;
        rd_row = '0;
        cycle(1'b1, 3'd1, mk_bus(ent(32'h400, 1'b0), '0, '0, '0), 1'b0, 1'b0);
        cycle(1'b0, 3'd0, '0, 1'b1, 1'b1);
        checks++; if (o_fetch_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_start got stall=%b want 1", o_fetch_stall); end
        i_rst_n = 1'b0;
        #1;
        checks++; if ({o_fetch_stall, o_wt_rd_en, o_flush, o_wt_wr_en} !== 4'b0000) begin errors++; $display("FAIL rst_mid_ctrl got %b want 0000", {o_fetch_stall, o_wt_rd_en, o_flush, o_wt_wr_en}); end
        checks++; if (o_pending !== 5'd0 || o_ghr !== '0) begin errors++; $display("FAIL rst_mid_ghr got pend=%0d ghr=%h want 0/0", o_pending, o_ghr); end
        m_reset();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            wr_seen += int'(o_wt_wr_en);
        end
        checks++; if (wr_seen != 0 || o_push_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_nowrite got writes=%0d rdy=%b want 0/1", wr_seen, o_push_ready); end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_push();
        test_resolve_correct();
        test_backpressure();
        test_mispredict();
        test_saturate();
        test_reset_mid_training();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
